// File: rtl/wheel_encoder_reader.sv
// Quadrature encoder reader: synchronizes and glitch-filters A/B, decodes 4x steps into a
// wrapping signed position, and reports steps per window as velocity. Optional index input via ENC_INDEX_EN.
module wheel_encoder_reader #(
    parameter int FILT_LEN   = 4,
    parameter int CNT_W      = 32,
    parameter int VEL_W      = 16,
    parameter int WINDOW_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
`ifdef ENC_INDEX_EN
    input  logic             enc_z,
`endif
    input  logic             pos_clr,
    input  logic             err_clr,
    output logic [CNT_W-1:0] pos,
    output logic             dir,
    output logic [VEL_W-1:0] vel,
    output logic             vel_valid,
`ifdef ENC_INDEX_EN
    output logic [CNT_W-1:0] idx_pos,
    output logic             idx_valid,
`endif
    output logic             err
);

`ifdef ENC_INDEX_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif
    localparam int FCW    = $clog2(FILT_LEN + 1);
    localparam int WCW    = $clog2(WINDOW_CYC);
    localparam int ACC_W  = VEL_W + 1;
    localparam int SW     = ACC_W + 1;

    localparam logic signed [SW-1:0] ACC_MAX = {2'b00, {VEL_W{1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = {2'b11, {VEL_W{1'b0}}};
    localparam logic signed [SW-1:0] VEL_MAX = {3'b000, {(VEL_W-1){1'b1}}};
    localparam logic signed [SW-1:0] VEL_MIN = {3'b111, {(VEL_W-1){1'b0}}};

    // Channel bit 0 = A, bit 1 = B, bit 2 = Z when present.
    logic [NCH-1:0] pins;
    logic [NCH-1:0] sync_1;
    logic [NCH-1:0] sync_2;
    logic [NCH-1:0] samp;
    logic [NCH-1:0] filt;
    logic [FCW-1:0] fcnt [NCH];

`ifdef ENC_INDEX_EN
    assign pins = {enc_z, enc_b, enc_a};
`else
    assign pins = {enc_b, enc_a};
`endif

    // Two metastability flops, then a sample register feeding the filter comparators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
            samp   <= '0;
        end else begin
            sync_1 <= pins;
            sync_2 <= sync_1;
            samp   <= sync_2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < NCH; i++) fcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (samp[i] != filt[i]) begin
                    if (fcnt[i] == FCW'(FILT_LEN - 1)) begin
                        filt[i] <= samp[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 1'b1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    // Gray phase index: forward rotation 00->10->11->01 is +1 modulo 4.
    function automatic logic [1:0] phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   phase_of = 2'd0;
            2'b10:   phase_of = 2'd1;
            2'b11:   phase_of = 2'd2;
            default: phase_of = 2'd3;
        endcase
    endfunction

    logic [1:0]           ab_prev;
    logic [1:0]           ab_cur;
    logic [1:0]           delta;
    logic                 step_fwd;
    logic                 step_rev;
    logic                 illegal;
    logic signed [SW-1:0] step_val;
    logic signed [SW-1:0] sum;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sat;
    logic [VEL_W-1:0]     vel_sat;
    logic [WCW-1:0]       win_cnt;
    logic                 win_end;

    assign ab_cur  = {filt[0], filt[1]};
    assign win_end = (win_cnt == WCW'(WINDOW_CYC - 1));

    always_comb begin
        delta    = phase_of(ab_cur) - phase_of(ab_prev);
        step_fwd = (delta == 2'd1);
        step_rev = (delta == 2'd3);
        illegal  = (delta == 2'd2);
        step_val = '0;
        if (step_fwd) begin
            step_val = {{(SW-1){1'b0}}, 1'b1};
        end else if (step_rev) begin
            step_val = '1;
        end
        sum = {acc[ACC_W-1], acc} + step_val;
        if (sum > ACC_MAX) begin
            acc_sat = ACC_MAX[ACC_W-1:0];
        end else if (sum < ACC_MIN) begin
            acc_sat = ACC_MIN[ACC_W-1:0];
        end else begin
            acc_sat = sum[ACC_W-1:0];
        end
        if (sum > VEL_MAX) begin
            vel_sat = VEL_MAX[VEL_W-1:0];
        end else if (sum < VEL_MIN) begin
            vel_sat = VEL_MIN[VEL_W-1:0];
        end else begin
            vel_sat = sum[VEL_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_prev <= 2'b00;
            pos     <= '0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else begin
            ab_prev <= ab_cur;
            if (pos_clr) begin
                pos <= '0;
            end else if (step_fwd) begin
                pos <= pos + CNT_W'(1);
            end else if (step_rev) begin
                pos <= pos - CNT_W'(1);
            end
            if (step_fwd) begin
                dir <= 1'b1;
            end else if (step_rev) begin
                dir <= 1'b0;
            end
            // A new illegal transition outranks a simultaneous clear.
            if (illegal) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            acc       <= '0;
            vel       <= '0;
            vel_valid <= 1'b0;
        end else begin
            if (win_end) begin
                win_cnt   <= '0;
                acc       <= '0;
                vel       <= vel_sat;
                vel_valid <= 1'b1;
            end else begin
                win_cnt   <= win_cnt + 1'b1;
                acc       <= acc_sat;
                vel_valid <= 1'b0;
            end
        end
    end

`ifdef ENC_INDEX_EN
    logic z_prev;

    // idx_pos captures pos as it stood before this cycle's step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_prev    <= 1'b0;
            idx_pos   <= '0;
            idx_valid <= 1'b0;
        end else begin
            z_prev    <= filt[2];
            idx_valid <= filt[2] & ~z_prev;
            if (filt[2] & ~z_prev) begin
                idx_pos <= pos;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wheel_encoder_reader.sv
// Directed bench for wheel_encoder_reader: latency, counting, glitch filter, errors,
// pos_clr, velocity windows with saturation (second instance has VEL_W=4), and mid-run reset.
module tb_wheel_encoder_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enc_a;
    logic        enc_b;
    logic        pos_clr;
    logic        err_clr;
    logic [31:0] pos;
    logic        dir;
    logic [15:0] vel;
    logic        vel_valid;
    logic        err;
    logic [31:0] pos2;
    logic        dir2;
    logic [3:0]  vel2;
    logic        vel_valid2;
    logic        err2;

    int total = 0;
    int bad   = 0;
    int cyc;
    logic [1:0] ab;

    int          vv_n;
    int          first_vv;
    int          last_vv;
    int          prev_vv;
    logic        vv_wide;
    logic        vv_last_s;
    logic [15:0] last_vel;
    logic [3:0]  last_vel2;

    wheel_encoder_reader #(.FILT_LEN(4), .CNT_W(32), .VEL_W(16), .WINDOW_CYC(100)) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .pos_clr(pos_clr), .err_clr(err_clr),
        .pos(pos), .dir(dir), .vel(vel), .vel_valid(vel_valid), .err(err)
    );

    wheel_encoder_reader #(.FILT_LEN(4), .CNT_W(32), .VEL_W(4), .WINDOW_CYC(100)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b),
        .pos_clr(pos_clr), .err_clr(err_clr),
        .pos(pos2), .dir(dir2), .vel(vel2), .vel_valid(vel_valid2), .err(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            vv_n = 0; first_vv = 0; last_vv = 0; prev_vv = 0;
            vv_wide = 1'b0; vv_last_s = 1'b0; last_vel = '0; last_vel2 = '0;
        end else begin
            if (vel_valid) begin
                if (vv_n == 0) first_vv = cyc;
                prev_vv   = last_vv;
                last_vv   = cyc;
                last_vel  = vel;
                last_vel2 = vel2;
                vv_n++;
                if (vv_last_s) vv_wide = 1'b1;
            end
            vv_last_s = vel_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] next_ab(input bit fwd, input logic [1:0] cur);
        case (cur)
            2'b00:   return fwd ? 2'b10 : 2'b01;
            2'b10:   return fwd ? 2'b11 : 2'b00;
            2'b11:   return fwd ? 2'b01 : 2'b10;
            default: return fwd ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic drive_ab(input logic [1:0] v);
        ab    = v;
        enc_a = v[1];
        enc_b = v[0];
    endtask

    task automatic quad(input bit fwd, input int n, input int hold);
        for (int i = 0; i < n; i++) begin
            drive_ab(next_ab(fwd, ab));
            tick(hold);
        end
    endtask

    task automatic wait_vv(input string tag);
        int k;
        k = 0;
        tick(1);
        while (vel_valid !== 1'b1 && k < 300) begin
            tick(1);
            k++;
        end
        check(tag, vel_valid, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pos_clr = 1'b0; err_clr = 1'b0;
        drive_ab(2'b00);
        tick(3);
        check("rst_pos", $signed(pos), 0);
        check("rst_dir", dir, 0);
        check("rst_vel", $signed(vel), 0);
        check("rst_vel_valid", vel_valid, 0);
        check("rst_err", err, 0);
        check("rst_vel2", $signed(vel2), 0);
        check("rst_vel_valid2", vel_valid2, 0);
        rst_n = 1'b1;
        tick(2);

        // First pin change: pos must move on exactly the 8th edge (edge index 7).
        drive_ab(2'b10);
        tick(7);
        check("latency_edge6", $signed(pos), 0);
        tick(1);
        check("latency_edge7", $signed(pos), 1);
        tick(2);
        quad(1, 31, 10);
        check("fwd_pos", $signed(pos), 32);
        check("fwd_dir", dir, 1);
        check("fwd_err", err, 0);
        check("fwd_pos2", $signed(pos2), 32);
        check("fwd_vel", $signed(last_vel), 10);
        check("fwd_vel2_sat", $signed(last_vel2), 7);
        check("first_vv_cycle", first_vv, 100);
        check("vv_interval", last_vv - prev_vv, 100);

        quad(0, 40, 10);
        check("rev_pos", $signed(pos), -8);
        check("rev_pos_bits", pos, 32'hFFFF_FFF8);
        check("rev_dir", dir, 0);
        check("rev_dir2", dir2, 0);
        check("rev_vel", $signed(last_vel), -10);
        check("rev_vel2_sat", $signed(last_vel2), -8);

        // Glitches on A: 3 cycles is rejected, 4 cycles passes both ways.
        enc_a = 1'b1; tick(3); enc_a = 1'b0; tick(15);
        check("glitch3_pos", $signed(pos), -8);
        check("glitch3_err", err, 0);
        enc_a = 1'b1; tick(4); enc_a = 1'b0;
        tick(4);
        check("glitch4_up_pos", $signed(pos), -7);
        check("glitch4_up_dir", dir, 1);
        tick(4);
        check("glitch4_down_pos", $signed(pos), -8);
        check("glitch4_down_dir", dir, 0);
        tick(5);
        check("glitch4_err", err, 0);

        drive_ab(2'b11);
        tick(12);
        check("illegal_err", err, 1);
        check("illegal_err2", err2, 1);
        check("illegal_pos", $signed(pos), -8);
        check("illegal_dir", dir, 0);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check("err_clr", err, 0);
        drive_ab(2'b00);
        tick(7);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check("err_set_wins", err, 1);
        tick(10);
        check("illegal2_pos", $signed(pos), -8);

        wait_vv("vv_wait_a");
        wait_vv("vv_wait_b");
        check("quiet_vel", $signed(vel), 0);
        check("quiet_vel2", $signed(vel2), 0);

        // Step lands in the same cycle as pos_clr.
        drive_ab(2'b10);
        tick(7);
        pos_clr = 1'b1; tick(1); pos_clr = 1'b0;
        check("pos_clr_pos", $signed(pos), 0);
        check("pos_clr_dir", dir, 1);
        wait_vv("vv_wait_c");
        check("pos_clr_vel", $signed(vel), 1);
        check("pos_clr_vel2", $signed(vel2), 1);
        tick(1);
        check("vv_one_cycle", vel_valid, 0);

        quad(1, 48, 5);
        check("fast_vel", $signed(last_vel), 20);
        check("fast_vel2_sat", $signed(last_vel2), 7);
        check("fast_interval", last_vv - prev_vv, 100);
        check("vv_never_wide", vv_wide, 0);
        tick(10);
        check("fast_pos", $signed(pos), 48);
        check("fast_err_sticky", err, 1);

        // Asynchronous reset in the middle of operation.
        rst_n = 1'b0;
        #2;
        check("mid_rst_pos", $signed(pos), 0);
        check("mid_rst_dir", dir, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_vel", $signed(vel), 0);
        check("mid_rst_vel2", $signed(vel2), 0);
        drive_ab(2'b00);
        tick(3);
        rst_n = 1'b1;
        tick(99);
        check("post_rst_vv_99", vel_valid, 0);
        tick(1);
        check("post_rst_vv_100", vel_valid, 1);
        check("post_rst_vel", $signed(vel), 0);
        tick(1);
        check("post_rst_vv_101", vel_valid, 0);
        check("post_rst_pos", $signed(pos), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
